// File: rtl/dcache_bus_pkg.sv
// -----------------------------------------------------------------------------
// dcache_bus_pkg
// Constants and types shared between the data cache and its device-side
// bus bridge.
//   BLK_LEN      words per cache line
//   BLK_SIZE     bits per cache line
//   UNCACHED_HI  addr[31:16] value marking uncached (peripheral) space
//   bridge_state_e  dev_bus_bridge sequencing states
// -----------------------------------------------------------------------------
package dcache_bus_pkg;

    localparam int unsigned BLK_LEN     = 4;
    localparam int unsigned BLK_SIZE    = BLK_LEN * 32;
    localparam logic [15:0] UNCACHED_HI = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } bridge_state_e;

endpackage

// File: rtl/dev_line_asm.sv
// -----------------------------------------------------------------------------
// dev_line_asm
// Refill line assembly register plus beat counter.
//   cpu_clk  clock, rising edge
//   cpu_rst  asynchronous active-high reset (line and beat to 0)
//   clr      clear line and beat (read capture)
//   load     store din into word [beat] and advance beat
//   din      32-bit word from memory
//   beat     current beat index
//   line     assembled line, word i at bits [32i+31:32i]
// -----------------------------------------------------------------------------
module dev_line_asm #(
    parameter int unsigned BLK_LEN = 4,
    parameter int unsigned BEAT_W  = 2
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic                   clr,
    input  logic                   load,
    input  logic [31:0]            din,
    output logic [BEAT_W-1:0]      beat,
    output logic [BLK_LEN*32-1:0]  line
);

    logic [BLK_LEN-1:0][31:0] words;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            words <= '0;
            beat  <= '0;
        end else if (clr) begin
            words <= '0;
            beat  <= '0;
        end else if (load) begin
            words[beat] <= din;
            beat        <= beat + BEAT_W'(1);
        end
    end

    assign line = words;

endmodule

// File: rtl/dev_bus_bridge.sv
// -----------------------------------------------------------------------------
// dev_bus_bridge
// Bridges the data cache's dev_* refill/write bus onto a 32-bit request/grant
// memory port. Cached reads fetch a whole line in BLK_LEN beats, uncached reads
// fetch one word, writes are a single beat. Pending writes go before reads.
//   cpu_clk, cpu_rst            clock / async active-high reset
//   dev_rrdy, dev_ren, dev_raddr    read request handshake
//   dev_rvalid, dev_rdata           one-cycle completion pulse, assembled line
//   dev_wrdy, dev_wen, dev_waddr, dev_wdata   write request handshake
//   mem_req..mem_wdata          memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata  memory grant / read return
// -----------------------------------------------------------------------------
module dev_bus_bridge #(
    parameter int unsigned BLK_LEN     = dcache_bus_pkg::BLK_LEN,
    parameter logic [15:0] UNCACHED_HI = dcache_bus_pkg::UNCACHED_HI
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    output logic                   dev_rrdy,
    input  logic [3:0]             dev_ren,
    input  logic [31:0]            dev_raddr,
    output logic                   dev_rvalid,
    output logic [BLK_LEN*32-1:0]  dev_rdata,
    output logic                   dev_wrdy,
    input  logic [3:0]             dev_wen,
    input  logic [31:0]            dev_waddr,
    input  logic [31:0]            dev_wdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata
);

    import dcache_bus_pkg::*;

    localparam int unsigned BEAT_W    = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [31:0] LINE_MASK = 32'(BLK_LEN * 4 - 1);

    bridge_state_e     state;
    logic              rd_pend, wr_pend;
    logic [31:0]       rd_base_q;
    logic              rd_unc_q;
    logic [3:0]        ren_q;
    logic [31:0]       waddr_q, wdata_q;
    logic [3:0]        wen_q;
    logic [BEAT_W-1:0] beat;

    logic              rd_cap, wr_cap;
    logic              cap_unc;
    logic [31:0]       cap_base;
    logic              rd_unc_eff;
    logic [31:0]       rd_base_eff, waddr_eff, wdata_eff;
    logic [3:0]        ren_eff, wen_eff;
    logic              beat_load, last_beat;

    assign rd_cap = dev_rrdy && (dev_ren != '0);
    assign wr_cap = dev_wrdy && (dev_wen != '0);

    assign cap_unc  = (dev_raddr[31:16] == UNCACHED_HI);
    assign cap_base = cap_unc ? (dev_raddr & ~32'h3) : (dev_raddr & ~LINE_MASK);

    // IDLE may start a request on the very edge it is captured, so it looks
    // at the live inputs as well as the latched copies.
    assign rd_unc_eff  = rd_cap ? cap_unc  : rd_unc_q;
    assign rd_base_eff = rd_cap ? cap_base : rd_base_q;
    assign ren_eff     = rd_cap ? dev_ren  : ren_q;
    assign waddr_eff   = wr_cap ? dev_waddr : waddr_q;
    assign wen_eff     = wr_cap ? dev_wen   : wen_q;
    assign wdata_eff   = wr_cap ? dev_wdata : wdata_q;

    assign beat_load = (state == RD_WAIT) && mem_rvalid;
    assign last_beat = rd_unc_q || (beat == BEAT_W'(BLK_LEN - 1));

    dev_line_asm #(
        .BLK_LEN (BLK_LEN),
        .BEAT_W  (BEAT_W)
    ) u_line_asm (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .clr     (rd_cap),
        .load    (beat_load),
        .din     (mem_rdata),
        .beat    (beat),
        .line    (dev_rdata)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            rd_base_q  <= '0;
            rd_unc_q   <= 1'b0;
            ren_q      <= '0;
            waddr_q    <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            dev_rrdy   <= 1'b1;
            dev_wrdy   <= 1'b1;
            dev_rvalid <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            dev_rvalid <= 1'b0;

            if (rd_cap) begin
                rd_base_q <= cap_base;
                rd_unc_q  <= cap_unc;
                ren_q     <= dev_ren;
                rd_pend   <= 1'b1;
                dev_rrdy  <= 1'b0;
            end
            if (wr_cap) begin
                waddr_q  <= dev_waddr;
                wen_q    <= dev_wen;
                wdata_q  <= dev_wdata;
                wr_pend  <= 1'b1;
                dev_wrdy <= 1'b0;
            end

            // Pending-flag clears below override the capture sets above when a
            // request is consumed on the same edge it arrives.
            unique case (state)
                IDLE: begin
                    if (wr_pend || wr_cap) begin
                        state     <= WR_REQ;
                        wr_pend   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= waddr_eff & ~32'h3;
                        mem_be    <= wen_eff;
                        mem_wdata <= wdata_eff;
                    end else if (rd_pend || rd_cap) begin
                        state    <= RD_REQ;
                        rd_pend  <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_base_eff;
                        mem_be   <= rd_unc_eff ? ren_eff : 4'hF;
                    end
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        dev_wrdy <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        state   <= RD_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (last_beat) begin
                            state      <= RD_DONE;
                            dev_rvalid <= 1'b1;
                        end else begin
                            state    <= RD_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= rd_base_q + (32'(beat) + 32'd1) * 32'd4;
                        end
                    end
                end
                RD_DONE: begin
                    state    <= IDLE;
                    dev_rrdy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dev_bus_bridge
// Directed bench for dev_bus_bridge with a small request/grant memory model.
// -----------------------------------------------------------------------------
module tb_dev_bus_bridge;

    logic         cpu_clk = 1'b0;
    logic         cpu_rst;
    logic         dev_rrdy, dev_rvalid, dev_wrdy;
    logic [3:0]   dev_ren, dev_wen;
    logic [31:0]  dev_raddr, dev_waddr, dev_wdata;
    logic [127:0] dev_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_be;
    logic         mem_gnt, mem_rvalid;
    logic [31:0]  mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    // memory model state
    int unsigned gnt_delay = 0;
    int unsigned rv_delay  = 0;
    int unsigned gnt_cnt   = 0;
    int unsigned rv_cnt    = 0;
    bit          rv_pending = 1'b0;
    bit          stray_req  = 1'b0;
    logic [31:0] rv_data    = '0;
    logic [31:0] rd_tbl [4];
    int          n_gnt     = 0;
    int          extra_req = 0;
    logic [31:0] g_addr  [16];
    logic [3:0]  g_be    [16];
    logic        g_we    [16];
    logic [31:0] g_wdata [16];

    // observation results
    int first_v, first_r, pulses;

    dev_bus_bridge #(
        .BLK_LEN     (4),
        .UNCACHED_HI (16'hFFFF)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .dev_rrdy   (dev_rrdy),
        .dev_ren    (dev_ren),
        .dev_raddr  (dev_raddr),
        .dev_rvalid (dev_rvalid),
        .dev_rdata  (dev_rdata),
        .dev_wrdy   (dev_wrdy),
        .dev_wen    (dev_wen),
        .dev_waddr  (dev_waddr),
        .dev_wdata  (dev_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: grants after gnt_delay waiting cycles, returns read data
    // rv_delay cycles after the cycle following the grant.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge cpu_clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (cpu_rst) begin
                rv_pending = 1'b0;
                gnt_cnt    = 0;
            end else begin
                if (rv_pending && mem_req) extra_req++;
                if (rv_pending) begin
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        rv_pending = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end else if (stray_req) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hBAD0_BAD0;
                    stray_req  = 1'b0;
                end
                if (mem_req) begin
                    if (gnt_cnt == gnt_delay) begin
                        mem_gnt = 1'b1;
                        gnt_cnt = 0;
                        if (n_gnt < 16) begin
                            g_addr[n_gnt]  = mem_addr;
                            g_be[n_gnt]    = mem_be;
                            g_we[n_gnt]    = mem_we;
                            g_wdata[n_gnt] = mem_wdata;
                        end
                        n_gnt++;
                        if (!mem_we) begin
                            rv_pending = 1'b1;
                            rv_cnt     = rv_delay;
                            rv_data    = rd_tbl[mem_addr[3:2]];
                        end
                    end else begin
                        gnt_cnt++;
                    end
                end else begin
                    gnt_cnt = 0;
                end
            end
        end
    end

    // Capture a read at edge T, then watch cycles T+1..T+max_cyc.
    task automatic do_read(input logic [31:0] a, input logic [3:0] be, input int max_cyc);
        @(negedge cpu_clk);
        dev_raddr = a;
        dev_ren   = be;
        @(posedge cpu_clk);
        first_v = 0;
        first_r = 0;
        pulses  = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge cpu_clk);
            if (k == 1) dev_ren = '0;
            if (dev_rvalid) begin
                pulses++;
                if (first_v == 0) first_v = k;
            end
            if (dev_rrdy && first_r == 0) first_r = k;
            if (first_r != 0 && k >= first_r + 2) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_q, first_w, unstable, found;

        cpu_rst   = 1'b1;
        dev_ren   = '0;
        dev_wen   = '0;
        dev_raddr = '0;
        dev_waddr = '0;
        dev_wdata = '0;
        for (int i = 0; i < 4; i++) rd_tbl[i] = '0;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);

        // reset state
        chk("rst_rrdy",   dev_rrdy,   1'b1);
        chk("rst_wrdy",   dev_wrdy,   1'b1);
        chk("rst_rvalid", dev_rvalid, 1'b0);
        chk("rst_rdata",  dev_rdata,  128'h0);
        chk("rst_req",    mem_req,    1'b0);
        chk("rst_we",     mem_we,     1'b0);
        chk("rst_addr",   mem_addr,   32'h0);
        chk("rst_be",     mem_be,     4'h0);
        chk("rst_wdata",  mem_wdata,  32'h0);
        cpu_rst = 1'b0;
        repeat (2) @(negedge cpu_clk);

        // cached refill, zero-wait memory
        rd_tbl[0] = 32'h11; rd_tbl[1] = 32'h22; rd_tbl[2] = 32'h33; rd_tbl[3] = 32'h44;
        n_gnt = 0;
        do_read(32'h0000_1230, 4'hF, 40);
        chk("c_rvalid_cyc", first_v, 9);
        chk("c_rvalid_pulses", pulses, 1);
        chk("c_rrdy_cyc", first_r, 10);
        chk("c_rdata", dev_rdata, 128'h00000044_00000033_00000022_00000011);
        chk("c_ngnt", n_gnt, 4);
        chk("c_addr0", g_addr[0], 32'h1230);
        chk("c_addr1", g_addr[1], 32'h1234);
        chk("c_addr2", g_addr[2], 32'h1238);
        chk("c_addr3", g_addr[3], 32'h123C);
        chk("c_be0", g_be[0], 4'hF);
        chk("c_we3", g_we[3], 1'b0);

        // uncached single beat
        rd_tbl[2] = 32'hDEAD_BEEF;
        n_gnt = 0;
        do_read(32'hFFFF_0008, 4'h3, 30);
        chk("u_rvalid_cyc", first_v, 3);
        chk("u_rvalid_pulses", pulses, 1);
        chk("u_rrdy_cyc", first_r, 4);
        chk("u_rdata", dev_rdata, {96'h0, 32'hDEAD_BEEF});
        chk("u_ngnt", n_gnt, 1);
        chk("u_addr", g_addr[0], 32'hFFFF_0008);
        chk("u_be", g_be[0], 4'h3);

        // write with grant delayed 3 cycles
        gnt_delay = 3;
        n_gnt = 0;
        @(negedge cpu_clk);
        dev_waddr = 32'h0000_0106;
        dev_wen   = 4'hC;
        dev_wdata = 32'hA5A5_0000;
        @(posedge cpu_clk);
        first_q  = 0;
        first_w  = 0;
        unstable = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge cpu_clk);
            if (k == 1) dev_wen = '0;
            if (mem_req) begin
                if (first_q == 0) first_q = k;
                if (mem_addr !== 32'h104 || mem_be !== 4'hC ||
                    mem_wdata !== 32'hA5A5_0000 || mem_we !== 1'b1) unstable++;
            end
            if (dev_wrdy && first_w == 0) first_w = k;
            if (first_w != 0) break;
        end
        gnt_delay = 0;
        chk("w_req_cyc", first_q, 1);
        chk("w_wrdy_cyc", first_w, 5);
        chk("w_stable", unstable, 0);
        chk("w_ngnt", n_gnt, 1);
        chk("w_addr", g_addr[0], 32'h104);
        chk("w_be", g_be[0], 4'hC);
        chk("w_we", g_we[0], 1'b1);
        chk("w_wdata", g_wdata[0], 32'hA5A5_0000);

        // simultaneous read and write: write served first
        n_gnt = 0;
        @(negedge cpu_clk);
        dev_raddr = 32'h0000_0040;
        dev_ren   = 4'hF;
        dev_waddr = 32'h0000_0080;
        dev_wen   = 4'hF;
        dev_wdata = 32'h1234_5678;
        @(posedge cpu_clk);
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge cpu_clk);
            if (k == 1) begin
                dev_ren = '0;
                dev_wen = '0;
            end
            if (dev_rrdy && dev_wrdy) begin
                found = 1;
                break;
            end
        end
        chk("s_both_rdy", found, 1);
        chk("s_ngnt", n_gnt, 5);
        chk("s_first_we", g_we[0], 1'b1);
        chk("s_first_addr", g_addr[0], 32'h80);
        chk("s_wdata", g_wdata[0], 32'h1234_5678);
        chk("s_rd_we", g_we[1], 1'b0);
        chk("s_rd_addr0", g_addr[1], 32'h40);
        chk("s_rd_addr3", g_addr[4], 32'h4C);

        // slow read returns, then stray rvalid while idle
        rv_delay = 5;
        extra_req = 0;
        n_gnt = 0;
        rd_tbl[0] = 32'hA000_0001; rd_tbl[1] = 32'hA000_0002;
        rd_tbl[2] = 32'hA000_0003; rd_tbl[3] = 32'hA000_0004;
        do_read(32'h0000_2000, 4'hF, 60);
        rv_delay = 0;
        chk("d_rvalid_cyc", first_v, 29);
        chk("d_rrdy_cyc", first_r, 30);
        chk("d_rdata", dev_rdata, 128'hA0000004_A0000003_A0000002_A0000001);
        chk("d_extra_req", extra_req, 0);
        chk("d_ngnt", n_gnt, 4);
        stray_req = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge cpu_clk);
            if (dev_rvalid) pulses++;
        end
        chk("i_stray_pulses", pulses, 0);
        chk("i_stray_rdata", dev_rdata, 128'hA0000004_A0000003_A0000002_A0000001);
        chk("i_stray_req", mem_req, 1'b0);

        // reset during beat 2 of a refill
        gnt_delay = 2;
        n_gnt = 0;
        @(negedge cpu_clk);
        dev_raddr = 32'h0000_0300;
        dev_ren   = 4'hF;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        dev_ren = '0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge cpu_clk);
            #1;
            if (mem_req && n_gnt == 2) begin
                found = 1;
                break;
            end
        end
        chk("r_beat2_seen", found, 1);
        cpu_rst = 1'b1;
        #1;
        chk("r_req_async", mem_req, 1'b0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst   = 1'b0;
        gnt_delay = 0;
        stray_req = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge cpu_clk);
            if (dev_rvalid) pulses++;
        end
        chk("r_rvalid_pulses", pulses, 0);
        chk("r_rrdy", dev_rrdy, 1'b1);
        chk("r_wrdy", dev_wrdy, 1'b1);
        chk("r_req_idle", mem_req, 1'b0);
        chk("r_rdata", dev_rdata, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
